gba_rom_loader: RTL and testbench

Downstream consumer of the IO subsystem's ROM loading byte stream. Tracks `rom_loading` sessions, packs `rom_do` bytes into little-endian 16-bit halfwords, buffers them in a small FIFO and writes them to SDRAM through a request/ready handshake. Cart backup bytes bypass the FIFO and go straight to the byte-wide backup BSRAM port. At session end it reports the loaded size and status to the GBA core.

---
 rtl/gba_rom_loader.sv | 265 ++++++++++++++++++++++++++
 tb/tb_gba_rom_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_rom_loader.sv
// Packs ROM/BIOS load bytes into halfword SDRAM writes through a small FIFO; backup bytes go to BSRAM.
// Optional macro GBA_HEADER_CHECK_EN enables the cartridge header complement check.
module gba_rom_loader #(
  parameter logic [22:0] ROM_BASE   = 23'h000000,
  parameter logic [22:0] BIOS_BASE  = 23'h7C0000,
  parameter logic [25:0] ROM_MAX    = 26'h2000000,
  parameter logic [25:0] BIOS_MAX   = 26'h0004000,
  parameter logic [25:0] BACKUP_MAX = 26'h0020000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  output logic        backup_we,
  output logic [16:0] backup_addr,
  output logic [7:0]  backup_din,
  output logic        load_busy,
  output logic        load_done,
  output logic [24:0] rom_size,
  output logic        overflow,
  output logic        header_ok
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_e;
  typedef enum logic [2:0] {
    M_NONE = 3'd0, M_ROM = 3'd1, M_BACKUP = 3'd2, M_CFG = 3'd3, M_BIOS = 3'd4
  } mode_e;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [24:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [7:0]  low_q, low_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic [24:0] size_q, size_d;
  logic        bwe_q, bwe_d;
  logic [16:0] baddr_q, baddr_d;
  logic [7:0]  bdin_q, bdin_d;

  logic [38:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   fcnt_q;
  logic          fifo_empty, fifo_full, push, pop;
  logic [38:0]   push_data;
  logic          req_q;
  logic [22:0]   addr_q;
  logic [15:0]   wdata_q;

  logic [25:0] limit_w;
  logic [22:0] base_w, pair_addr;
  logic        in_limit, done_entry;

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == DEPTH_CNT);
  assign pop        = req_q && mem_ready;

  always_comb begin
    limit_w = BACKUP_MAX;
    base_w  = ROM_BASE;
    if (mode_q == M_ROM) begin
      limit_w = ROM_MAX;
    end else if (mode_q == M_BIOS) begin
      limit_w = BIOS_MAX;
      base_w  = BIOS_BASE;
    end
  end

  assign in_limit   = ({1'b0, cnt_q} < limit_w);
  assign pair_addr  = base_w + {cnt_q[22:1], 1'b0};
  assign done_entry = (state_q == S_DRAIN) && (state_d == S_DONE);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    low_d     = low_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    size_d    = size_q;
    bwe_d     = 1'b0;
    baddr_d   = baddr_q;
    bdin_d    = bdin_q;
    push      = 1'b0;
    push_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rom_loading != 3'd0) begin
          state_d = S_LOAD;
          mode_d  = mode_e'(rom_loading);
          cnt_d   = '0;
          pend_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        if (rom_do_valid) begin
          if (cnt_q != '1) cnt_d = cnt_q + 25'd1;
          case (mode_q)
            M_ROM, M_BIOS: begin
              if (!in_limit) begin
                ovf_d = 1'b1;
              end else if (!cnt_q[0]) begin
                low_d  = rom_do;
                pend_d = 1'b1;
              end else begin
                pend_d = 1'b0;
                // a pop on the same edge frees the slot this push needs
                if (fifo_full && !pop) begin
                  ovf_d = 1'b1;
                end else begin
                  push      = 1'b1;
                  push_data = {pair_addr, rom_do, low_q};
                end
              end
            end
            M_BACKUP: begin
              if (!in_limit) begin
                ovf_d = 1'b1;
              end else begin
                bwe_d   = 1'b1;
                baddr_d = cnt_q[16:0];
                bdin_d  = rom_do;
              end
            end
            default: ;
          endcase
        end
        if (rom_loading == 3'd0) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (fifo_full && !pop) begin
            ovf_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {pair_addr, 8'hFF, low_q};
          end
        end
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && !req_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          if (mode_q == M_ROM)
            size_d = ({1'b0, cnt_q} > ROM_MAX) ? ROM_MAX[24:0] : cnt_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= M_NONE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      low_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      size_q  <= '0;
      bwe_q   <= 1'b0;
      baddr_q <= '0;
      bdin_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      low_q   <= low_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      size_q  <= size_d;
      bwe_q   <= bwe_d;
      baddr_q <= baddr_d;
      bdin_q  <= bdin_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= push_data;
  end

  // head entry stays in the FIFO until mem_ready, so it counts toward full
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      fcnt_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      fcnt_q <= fcnt_q + (PW+1)'(push) - (PW+1)'(pop);
      if (pop) begin
        req_q <= 1'b0;
      end else if (!req_q && !fifo_empty) begin
        req_q   <= 1'b1;
        addr_q  <= fifo_mem[rptr_q][38:16];
        wdata_q <= fifo_mem[rptr_q][15:0];
      end
    end
  end

`ifdef GBA_HEADER_CHECK_EN
  logic [7:0] sum_q, cmp_q, hdr_expect;
  logic       hok_q, rom_byte;

  assign rom_byte   = (state_q == S_LOAD) && rom_do_valid && (mode_q == M_ROM);
  assign hdr_expect = 8'h00 - sum_q - 8'h19;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      cmp_q <= '0;
      hok_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && (rom_loading != 3'd0)) begin
        sum_q <= '0;
        cmp_q <= '0;
      end else if (rom_byte) begin
        if ((cnt_q >= 25'hA0) && (cnt_q <= 25'hBC)) sum_q <= sum_q + rom_do;
        if (cnt_q == 25'hBD) cmp_q <= rom_do;
      end
      if (done_entry && (mode_q == M_ROM))
        hok_q <= (cmp_q == hdr_expect) && (cnt_q > 25'hBD);
    end
  end
`else
  logic hok_q;

  always_ff @(posedge clk) begin
    if (reset) hok_q <= 1'b0;
    else       hok_q <= 1'b1;
  end
`endif

  assign header_ok   = hok_q;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign backup_we   = bwe_q;
  assign backup_addr = baddr_q;
  assign backup_din  = bdin_q;
  assign load_busy   = busy_q;
  assign load_done   = (state_q == S_DONE);
  assign rom_size    = size_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_gba_rom_loader.sv
// Scoreboard bench for gba_rom_loader: session-level reference model fills expected-write queues,
// a negedge monitor pops and compares every SDRAM handshake and backup strobe.
module tb_gba_rom_loader;
  localparam logic [22:0] ROM_BASE   = 23'h000000;
  localparam logic [22:0] BIOS_BASE  = 23'h7C0000;
  localparam int unsigned ROM_MAX    = 32'h2000000;
  localparam int unsigned BIOS_MAX   = 32'h4000;
  localparam int unsigned BACKUP_MAX = 32'h20000;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned NOCAP      = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [22:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  rom_loading = '0;
  logic [7:0]  rom_do = '0;
  logic        rom_do_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, backup_we, load_busy, load_done, overflow, header_ok;
  logic [22:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [16:0] backup_addr;
  logic [7:0]  backup_din;
  logic [24:0] rom_size;

  wr_t         exp_wr[$];
  logic [24:0] exp_bk[$];
  logic [7:0]  sess[$];
  logic        exp_ovf = 1'b0;
  logic [24:0] exp_size = '0;
`ifdef GBA_HEADER_CHECK_EN
  logic        exp_hok = 1'b0;
`else
  logic        exp_hok = 1'b1;
`endif

  int unsigned errors = 0, checks = 0;
  bit          stall = 1'b0;
  int unsigned lat_min = 0, lat_max = 2;
  int unsigned burst_min = 1, burst_max = 4, gap_min = 5, gap_max = 7;

  gba_rom_loader #(
    .ROM_BASE  (ROM_BASE),
    .BIOS_BASE (BIOS_BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .backup_we(backup_we),
    .backup_addr(backup_addr), .backup_din(backup_din), .load_busy(load_busy),
    .load_done(load_done), .rom_size(rom_size), .overflow(overflow), .header_ok(header_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-session view of what the loader must write.
  function automatic void plan_session(input logic [2:0] mode, input int unsigned cap);
    int unsigned n = sess.size();
    int unsigned acc;
    logic [7:0]  sum;
    wr_t         w;
    exp_ovf = 1'b0;
    if (mode == 3'd1 || mode == 3'd4) begin
      int unsigned lim  = (mode == 3'd1) ? ROM_MAX : BIOS_MAX;
      logic [22:0] base = (mode == 3'd1) ? ROM_BASE : BIOS_BASE;
      acc = (n > lim) ? lim : n;
      exp_ovf = (n > lim);
      for (int unsigned k = 0; 2 * k < acc; k++) begin
        if (k >= cap) begin
          exp_ovf = 1'b1;
          break;
        end
        w.a = base + 23'(2 * k);
        w.d = {(2 * k + 1 < acc) ? sess[2*k+1] : 8'hFF, sess[2*k]};
        exp_wr.push_back(w);
      end
      if (mode == 3'd1) begin
        exp_size = 25'(acc);
`ifdef GBA_HEADER_CHECK_EN
        sum = 8'h00;
        for (int unsigned i = 32'hA0; i <= 32'hBC && i < n; i++) sum = sum + sess[i];
        exp_hok = 1'b0;
        if (n > 32'hBD) exp_hok = (sess[32'hBD] == 8'(8'h00 - sum - 8'h19));
`else
        sum = 8'h00;
`endif
      end
    end else if (mode == 3'd2) begin
      acc = (n > BACKUP_MAX) ? BACKUP_MAX : n;
      exp_ovf = (n > BACKUP_MAX);
      for (int unsigned i = 0; i < acc; i++) exp_bk.push_back({17'(i), sess[i]});
    end
  endfunction

  task automatic run_session(input logic [2:0] mode, input int unsigned cap, input int unsigned hold,
                             input bit coincide, input bit switch_mid);
    int unsigned n = sess.size();
    int unsigned waited = 0, t = 0, burst = 0, bl;
    plan_session(mode, cap);
    bl = $urandom_range(burst_min, burst_max);
    if (hold > 0) stall = 1'b1;
    @(negedge clk);
    rom_loading = mode;
    @(negedge clk);
    check("busy_start", 32'(load_busy), 1);
    check("ovf_cleared", 32'(overflow), 0);
    for (int unsigned i = 0; i < n; i++) begin
      rom_do = sess[i];
      rom_do_valid = 1'b1;
      if (switch_mid && i == n / 2) rom_loading = (mode == 3'd1) ? 3'd2 : 3'd1;
      if (coincide && i == n - 1) rom_loading = 3'd0;
      @(negedge clk);
      t++;
      burst++;
      if (burst == bl && i != n - 1) begin
        rom_do_valid = 1'b0;
        burst = 0;
        bl = $urandom_range(burst_min, burst_max);
        repeat ($urandom_range(gap_min, gap_max)) begin
          @(negedge clk);
          t++;
        end
      end
    end
    rom_do_valid = 1'b0;
    while (t < hold) begin
      @(negedge clk);
      t++;
    end
    stall = 1'b0;
    if (!coincide || n == 0) rom_loading = 3'd0;
    while (!load_done && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("load_done", 32'(load_done), 1);
    if (n == 0) check("empty_latency", waited, 3);
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("rom_size", 32'(rom_size), 32'(exp_size));
    check("header_ok", 32'(header_ok), 32'(exp_hok));
    check("writes_pending", exp_wr.size(), 0);
    check("backup_pending", exp_bk.size(), 0);
    exp_wr.delete();
    exp_bk.delete();
    @(negedge clk);
    check("done_pulse", 32'(load_done), 0);
    check("busy_end", 32'(load_busy), 0);
  endtask

  // SDRAM responder: mem_ready after a per-request latency
  initial begin
    int unsigned lat = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        lat = $urandom_range(lat_min, lat_max);
      end else if (mem_req && !stall && !reset) begin
        if (lat == 0) mem_ready = 1'b1;
        else lat--;
      end
    end
  end

  // Monitor
  initial begin
    wr_t         e;
    logic [24:0] b;
    logic        p_req = 1'b0, p_rdy = 1'b0;
    logic [22:0] p_addr = '0;
    logic [15:0] p_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (p_req && p_rdy) begin
          check("req_drop", 32'(mem_req), 0);
        end else if (p_req && mem_req) begin
          check("addr_stable", 32'(mem_addr), 32'(p_addr));
          check("data_stable", 32'(mem_wdata), 32'(p_data));
        end
        if (mem_req && mem_ready) begin
          if (exp_wr.size() == 0) begin
            check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e.a));
            check("wr_data", 32'(mem_wdata), 32'(e.d));
          end
        end
        if (backup_we) begin
          if (exp_bk.size() == 0) begin
            check("unexpected_backup", 32'(backup_addr), 32'hFFFF_FFFF);
          end else begin
            b = exp_bk.pop_front();
            check("bk_addr", 32'(backup_addr), 32'(b[24:8]));
            check("bk_data", 32'(backup_din), 32'(b[7:0]));
          end
        end
      end
      p_req  = mem_req;
      p_rdy  = mem_ready;
      p_addr = mem_addr;
      p_data = mem_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] s;
    logic [2:0] md;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_backup_we", 32'(backup_we), 0);
    check("rst_backup_addr", 32'(backup_addr), 0);
    check("rst_backup_din", 32'(backup_din), 0);
    check("rst_load_busy", 32'(load_busy), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_rom_size", 32'(rom_size), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_header_ok", 32'(header_ok), 0);
    reset = 1'b0;
    @(negedge clk);
    check("header_ok_idle", 32'(header_ok), 32'(exp_hok));

    lat_min = 1; lat_max = 1;
    sess = {8'h11, 8'h22, 8'h33, 8'h44};
    run_session(3'd1, NOCAP, 0, 1'b0, 1'b0);
    sess = {8'hAA, 8'hBB, 8'hCC};
    run_session(3'd1, NOCAP, 0, 1'b1, 1'b0);
    sess.delete();
    run_session(3'd1, NOCAP, 0, 1'b0, 1'b0);
    sess = {8'h5A, 8'hA5};
    run_session(3'd2, NOCAP, 0, 1'b0, 1'b0);

    lat_min = 0; lat_max = 2;
    burst_min = 4; burst_max = 4; gap_min = 4; gap_max = 4;
    sess.delete();
    for (int i = 0; i < 20; i++) sess.push_back(8'($urandom));
    run_session(3'd1, DEPTH, 40, 1'b0, 1'b0);

    burst_min = 1; burst_max = 4; gap_min = 5; gap_max = 7;
    sess.delete();
    for (int i = 0; i < 24; i++) sess.push_back(8'($urandom));
    run_session(3'd1, NOCAP, 0, 1'b0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      md = 3'($urandom_range(1, 4));
      sess.delete();
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) sess.push_back(8'($urandom));
      run_session(md, NOCAP, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    sess.delete();
    for (int i = 0; i < 192; i++) sess.push_back(8'($urandom));
    s = 8'h00;
    for (int i = 'hA0; i <= 'hBC; i++) s = s + sess[i];
    sess[32'hBD] = 8'h00 - s - 8'h19;
    run_session(3'd1, NOCAP, 0, 1'b0, 1'b0);
    sess[32'hBD] = sess[32'hBD] ^ 8'h01;
    run_session(3'd1, NOCAP, 0, 1'b1, 1'b0);

    lat_min = 0; lat_max = 0;
    burst_min = 4; burst_max = 4; gap_min = 2; gap_max = 2;
    sess.delete();
    for (int i = 0; i < 16386; i++) sess.push_back(8'($urandom));
    run_session(3'd4, NOCAP, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
